// File: rtl/peripheral_bus_slave_if.sv
// Peripheral start/bip/wait/error bus.
//
// Purpose : groups the transfer-request and data signals shared by a bus
//           master and the memory-backed peripheral_bus_slave.
// Signals : sig_addr     start address (beat granular), sampled with sig_start
//           sig_size     burst length code, beats = 1 << sig_size
//           sig_read     read request
//           sig_write    write request
//           sig_start    one-cycle transfer request
//           sig_bip      burst in progress, held high until the last beat
//           sig_data_in  write data, one word per beat
//           sig_data_out read data
//           sig_data_oe  sig_data_out valid / drive enable
//           sig_wait     slave not ready
//           sig_error    one-cycle error pulse
//
// Handshake: a transfer is requested by holding sig_start high for one cycle
// while the slave is idle, together with exactly one of sig_read/sig_write.
// The slave then holds sig_wait high for its wait states. Beats follow
// back-to-back with sig_wait low. Write data is taken at the rising edge that
// ends each beat cycle, and read data is valid in any cycle with sig_data_oe
// high. Dropping sig_bip before the last beat aborts the burst, and the slave
// reports any abort or rejected request with a single-cycle sig_error.
interface peripheral_bus_slave_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] sig_addr;
  logic [1:0]            sig_size;
  logic                  sig_read;
  logic                  sig_write;
  logic                  sig_start;
  logic                  sig_bip;
  logic [DATA_WIDTH-1:0] sig_data_in;
  logic [DATA_WIDTH-1:0] sig_data_out;
  logic                  sig_data_oe;
  logic                  sig_wait;
  logic                  sig_error;

  modport master (
    output sig_addr, sig_size, sig_read, sig_write, sig_start, sig_bip,
           sig_data_in,
    input  sig_data_out, sig_data_oe, sig_wait, sig_error
  );

  modport slave (
    input  sig_addr, sig_size, sig_read, sig_write, sig_start, sig_bip,
           sig_data_in,
    output sig_data_out, sig_data_oe, sig_wait, sig_error
  );
endinterface

// File: rtl/peripheral_bus_slave.sv
// Memory-backed target for the peripheral start/bip/wait/error bus.
//
// Purpose : accepts single and burst (1/2/4/8 beat) read/write transfers
//           into a DEPTH-word memory, with WAIT_STATES wait cycles after each
//           accepted start, burst abort via sig_bip, and either address
//           wrap-around (WRAP=1) or an error response (WRAP=0) at the top of
//           memory.
// Ports   : sig_clock    clock, rising edge
//           sig_reset    asynchronous reset, active low
//           bus          peripheral_bus_slave_if slave modport
//           o_dbg_state  current FSM state (0 IDLE, 1 WAIT, 2 DATA, 3 ERR)
module peripheral_bus_slave #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2,
  parameter int WRAP        = 0
) (
  input  logic                  sig_clock,
  input  logic                  sig_reset,
  peripheral_bus_slave_if.slave bus,
  output logic [1:0]            o_dbg_state
);

  localparam int                  MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_X   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [3:0]          WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t                r_state, w_state_n;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_n;
  logic                  r_read, w_read_n;
  logic [3:0]            r_beat_cnt, w_beat_cnt_n;  // beats remaining after the current one
  logic [3:0]            r_wait_cnt, w_wait_cnt_n;  // wait cycles remaining after the current one
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_oe;
  logic                  r_wait;
  logic                  r_error;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_req_ok;
  logic                  w_range_err;
  logic                  w_last_beat;
  logic                  w_abort;
  logic [3:0]            w_beats_m1;
  logic [ADDR_WIDTH:0]   w_end_addr;
  logic [ADDR_WIDTH-1:0] w_addr_inc;

  // Range check is one bit wider than the address so the end address of a
  // burst near the top of the address space cannot overflow.
  assign w_beats_m1  = (4'd1 << bus.sig_size) - 4'd1;
  assign w_end_addr  = {1'b0, bus.sig_addr} + (ADDR_WIDTH+1)'(w_beats_m1);
  assign w_range_err = ({1'b0, bus.sig_addr} >= DEPTH_X) ||
                       ((WRAP == 0) && (w_end_addr >= DEPTH_X));
  assign w_req_ok    = bus.sig_read ^ bus.sig_write;

  assign w_last_beat = (r_beat_cnt == 4'd0);
  assign w_abort     = (r_state == ST_DATA) && !w_last_beat && !bus.sig_bip;
  assign w_addr_inc  = (r_addr == LAST_ADDR) ? '0 : r_addr + ADDR_WIDTH'(1);

  always_comb begin
    w_state_n    = r_state;
    w_addr_n     = r_addr;
    w_read_n     = r_read;
    w_beat_cnt_n = r_beat_cnt;
    w_wait_cnt_n = r_wait_cnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.sig_start) begin
          if (!w_req_ok || w_range_err) begin
            w_state_n = ST_ERR;
          end else begin
            w_addr_n     = bus.sig_addr;
            w_read_n     = bus.sig_read;
            w_beat_cnt_n = w_beats_m1;
            w_wait_cnt_n = WAIT_LOAD;
            w_state_n    = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
          end
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt == 4'd0) w_state_n = ST_DATA;
        else                    w_wait_cnt_n = r_wait_cnt - 4'd1;
      end
      ST_DATA: begin
        if (w_abort) begin
          w_state_n = ST_ERR;
        end else if (w_last_beat) begin
          w_state_n = ST_IDLE;
        end else begin
          w_addr_n     = w_addr_inc;
          w_beat_cnt_n = r_beat_cnt - 4'd1;
        end
      end
      ST_ERR:  w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is valid for the
  // whole cycle the FSM spends in the matching state.
  always_ff @(posedge sig_clock or negedge sig_reset) begin
    if (!sig_reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_read     <= 1'b0;
      r_beat_cnt <= '0;
      r_wait_cnt <= '0;
      r_data_out <= '0;
      r_oe       <= 1'b0;
      r_wait     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_addr     <= w_addr_n;
      r_read     <= w_read_n;
      r_beat_cnt <= w_beat_cnt_n;
      r_wait_cnt <= w_wait_cnt_n;
      r_wait     <= (w_state_n == ST_WAIT);
      r_error    <= (w_state_n == ST_ERR);
      r_oe       <= (w_state_n == ST_DATA) && w_read_n;
      r_data_out <= ((w_state_n == ST_DATA) && w_read_n) ?
                    r_mem[w_addr_n[MEM_AW-1:0]] : '0;
    end
  end

  // Memory is not reset. Reset forces IDLE asynchronously, so no write can
  // land after reset is asserted mid-burst.
  always_ff @(posedge sig_clock) begin
    if ((r_state == ST_DATA) && !r_read && !w_abort) begin
      r_mem[r_addr[MEM_AW-1:0]] <= bus.sig_data_in;
    end
  end

  // An abort is only visible during the beat cycle itself, so the drive
  // enable is qualified by it to keep an aborted beat off the bus.
  assign bus.sig_data_out = r_data_out;
  assign bus.sig_data_oe  = r_oe & ~w_abort;
  assign bus.sig_wait     = r_wait;
  assign bus.sig_error    = r_error;
  assign o_dbg_state      = r_state;

endmodule
